async_ram_ctrl: RTL and testbench
=================================

ASYNC_RAM_CTRL -- requirements
Module: async_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 23, meaning word-address width driven on MemAdr.
REQ-002 Parameter RD_WAIT, default 4, meaning clock cycles CE/OE held low per read (legal 1..255).
REQ-003 Parameter WR_WAIT, default 4, meaning clock cycles CE/WE held low per write (legal 1..255).
REQ-004 Parameter TURN, default 1, meaning recovery cycles with CE high after every access (legal 1..255).
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  1  host presents a request.
REQ-008 req_ready  out  1  controller can accept a request this cycle.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  word address.
REQ-011 req_wdata  in  16  write data.
REQ-012 req_be  in  2  byte enables, bit0 = low byte, bit1 = high byte (writes only).
REQ-013 rd_valid  out  1  one-cycle pulse, rd_data valid.
REQ-014 rd_data  out  16  registered read data.
REQ-015 wr_done  out  1  one-cycle pulse, write strobe completed.
REQ-016 MemAdr  out  ADDR_W  RAM address, registered.
REQ-017 MemDB  inout  16  RAM data bus, tristated when not writing.
REQ-018 RamCE, MemOE, MemWE  out  1 each  active-low RAM strobes, registered.
REQ-019 RamLB, RamUB  out  1 each  active-low byte lanes, registered.
REQ-020 RamAdv, RamClk  out  1 each  held 0 (asynchronous mode); FlashCE  out  1  held 1.

Function
REQ-021 FSM states IDLE, READ, WRITE, RECOVER; req_ready = 1 only in IDLE.
REQ-022 Handshake: request accepted in a cycle where req_valid & req_ready; req_we/addr/wdata/be captured on that edge; inputs ignored otherwise.
REQ-023 Accept read at cycle 0: READ occupies cycles 1..RD_WAIT with RamCE=0, MemOE=0, MemWE=1, RamLB=RamUB=0, MemAdr=captured address.
REQ-024 MemDB sampled into rd_data on the edge ending cycle RD_WAIT; rd_valid=1 in cycle RD_WAIT+1 only; rd_data holds until next read completes.
REQ-025 Accept write at cycle 0: WRITE occupies cycles 1..WR_WAIT with RamCE=0, MemWE=0, MemOE=1, RamLB=~be[0], RamUB=~be[1], MemDB driven with captured data.
REQ-026 Write with req_be=2'b00 still runs full timing with RamLB=RamUB=1; wr_done still pulses.
REQ-027 RECOVER occupies TURN cycles after READ/WRITE with RamCE=MemOE=MemWE=1, RamLB=RamUB=1; MemAdr held.
REQ-028 After WRITE, MemDB stays driven with write data through first RECOVER cycle (data hold), tristated afterwards; wr_done=1 in that first RECOVER cycle only.
REQ-029 MemDB is never driven while MemOE=0; OE-low and bus-drive never overlap in any cycle.
REQ-030 Return to IDLE after last RECOVER cycle; with defaults, back-to-back requests accepted every RD_WAIT+TURN+1 (6) cycles.
REQ-031 Wait/recovery counter wide enough for 255; counts down, no wrap-around; parameter value 0 treated as 1.
REQ-032 rd_valid and wr_done never asserted in the same cycle.

Reset
REQ-033 rstn=0 at an edge: state IDLE, counter 0, RamCE=MemOE=MemWE=1, RamLB=RamUB=1, MemDB tristated, MemAdr=0, rd_data=0, rd_valid=wr_done=0, req_ready=1 in following cycle.
REQ-034 Reset mid-access aborts immediately at that edge; no rd_valid/wr_done for the aborted request; a request presented while rstn=0 is not accepted.

Verification
REQ-035 Read, defaults: accept addr 0x00ABCD cycle 0, RAM model returns 0x1234 -> CE/OE low cycles 1-4, rd_valid=1 & rd_data=0x1234 cycle 5, req_ready=1 cycle 6.
REQ-036 Write addr 0x000010 data 0xBEEF be=2'b11 -> WE low cycles 1-4, MemDB=0xBEEF cycles 1-5, wr_done cycle 5, bus Z cycle 6; readback returns 0xBEEF.
REQ-037 Byte write be=2'b01 data 0x55AA over 0xFFFF -> RamLB=0, RamUB=1 during WE low; readback 0xFFAA.
REQ-038 req_valid held high with alternating write/read for 20 requests -> one acceptance per 6 cycles, no OE/bus-drive overlap, all readbacks match.
REQ-039 rstn low during cycle 2 of a write -> strobes high and bus Z next edge, no wr_done, req_ready=1 after rstn released.
REQ-040 RD_WAIT=1, WR_WAIT=1, TURN=3 instance -> read rd_valid cycle 2, next accept cycle 5; all strobe timings scale accordingly.

Source files
------------

// File: rtl/async_ram_ctrl_if.sv
// Host-side request/response bundle for async_ram_ctrl.
//   master : host; drives req_valid/req_we/req_addr/req_wdata/req_be, and
//            receives req_ready, rd_valid, rd_data and wr_done.
//   slave  : controller; the mirror image of master.
interface async_ram_ctrl_if #(
  parameter int unsigned ADDR_W = 23
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic [1:0]        req_be;
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic              wr_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rd_valid, rd_data, wr_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rd_valid, rd_data, wr_done
  );
endinterface

// File: rtl/async_ram_ctrl.sv
// Asynchronous-mode 16-bit PSRAM/SRAM controller. It performs one word access
// per accepted host request, holds the strobes low for a fixed number of
// cycles, and then enforces a recovery gap with CE high.
//   clk, rstn : clock and synchronous active-low reset
//   host      : request/response handshake (slave side of async_ram_ctrl_if)
//   MemAdr    : registered word address
//   MemDB     : bidirectional data bus, driven only during writes
//   RamCE, MemOE, MemWE, RamLB, RamUB : registered active-low strobes
//   RamAdv, RamClk, FlashCE : tied to their asynchronous-mode levels
module async_ram_ctrl #(
  parameter int unsigned ADDR_W  = 23,
  parameter int unsigned RD_WAIT = 4,
  parameter int unsigned WR_WAIT = 4,
  parameter int unsigned TURN    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  async_ram_ctrl_if.slave   host,
  output logic [ADDR_W-1:0] MemAdr,
  inout  wire  [15:0]       MemDB,
  output logic              RamCE,
  output logic              MemOE,
  output logic              MemWE,
  output logic              RamLB,
  output logic              RamUB,
  output logic              RamAdv,
  output logic              RamClk,
  output logic              FlashCE
);

  localparam int unsigned CNT_W   = 8;
  // A zero setting would give no strobe phase at all; clamp it to one cycle.
  localparam int unsigned RD_EFF  = (RD_WAIT == 0) ? 1 : RD_WAIT;
  localparam int unsigned WR_EFF  = (WR_WAIT == 0) ? 1 : WR_WAIT;
  localparam int unsigned TRN_EFF = (TURN    == 0) ? 1 : TURN;
  // The counter holds the cycles remaining after the current one.
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_EFF - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_EFF - 1);
  localparam logic [CNT_W-1:0] TRN_LOAD = CNT_W'(TRN_EFF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             accept;

  logic             ceNext;
  logic             oeNext;
  logic             weNext;
  logic             lbNext;
  logic             ubNext;
  logic             driveNext;
  logic             rdValidNext;
  logic             wrDoneNext;

  logic             driveEn;
  logic [15:0]      wdataQ;
  logic [15:0]      rdDataQ;
  logic             rdValidQ;
  logic             wrDoneQ;
  logic             readyQ;

  // State and wait counter register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state, counter, and the next values of every registered output.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    accept      = 1'b0;
    ceNext      = 1'b1;
    oeNext      = 1'b1;
    weNext      = 1'b1;
    lbNext      = 1'b1;
    ubNext      = 1'b1;
    driveNext   = 1'b0;
    rdValidNext = 1'b0;
    wrDoneNext  = 1'b0;

    case (state)
      IDLE: begin
        if (host.req_valid) begin
          accept    = 1'b1;
          stateNext = host.req_we ? WRITE : READ;
          cntNext   = host.req_we ? WR_LOAD : RD_LOAD;
        end
      end
      READ, WRITE: begin
        if (cnt == '0) begin
          stateNext = RECOVER;
          cntNext   = TRN_LOAD;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt == '0) begin
          stateNext = IDLE;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase

    case (stateNext)
      READ: begin
        ceNext = 1'b0;
        oeNext = 1'b0;
        lbNext = 1'b0;
        ubNext = 1'b0;
      end
      WRITE: begin
        ceNext = 1'b0;
        weNext = 1'b0;
        // Lanes come from the request on the accepting edge, then are held.
        lbNext = accept ? ~host.req_be[0] : RamLB;
        ubNext = accept ? ~host.req_be[1] : RamUB;
      end
      default: ;
    endcase

    // Bus stays driven one cycle past WE rising to give the RAM data hold.
    driveNext   = (stateNext == WRITE) || ((state == WRITE) && (stateNext == RECOVER));
    rdValidNext = (state == READ)  && (stateNext == RECOVER);
    wrDoneNext  = (state == WRITE) && (stateNext == RECOVER);
  end

  // Registered strobes, address, write data and host responses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      RamCE    <= 1'b1;
      MemOE    <= 1'b1;
      MemWE    <= 1'b1;
      RamLB    <= 1'b1;
      RamUB    <= 1'b1;
      MemAdr   <= '0;
      driveEn  <= 1'b0;
      wdataQ   <= '0;
      rdDataQ  <= '0;
      rdValidQ <= 1'b0;
      wrDoneQ  <= 1'b0;
      readyQ   <= 1'b1;
    end else begin
      RamCE    <= ceNext;
      MemOE    <= oeNext;
      MemWE    <= weNext;
      RamLB    <= lbNext;
      RamUB    <= ubNext;
      driveEn  <= driveNext;
      rdValidQ <= rdValidNext;
      wrDoneQ  <= wrDoneNext;
      readyQ   <= (stateNext == IDLE);
      if (accept) begin
        MemAdr <= host.req_addr;
      end
      if (accept && host.req_we) begin
        wdataQ <= host.req_wdata;
      end
      // Sampled on the edge that ends the last OE-low cycle.
      if (rdValidNext) begin
        rdDataQ <= MemDB;
      end
    end
  end

  assign MemDB = driveEn ? wdataQ : 16'hzzzz;

  assign host.req_ready = readyQ;
  assign host.rd_valid  = rdValidQ;
  assign host.rd_data   = rdDataQ;
  assign host.wr_done   = wrDoneQ;

  assign RamAdv  = 1'b0;
  assign RamClk  = 1'b0;
  assign FlashCE = 1'b1;

endmodule

// File: tb/tb_async_ram_ctrl.sv
// Self-checking bench for async_ram_ctrl: a default instance and a
// RD_WAIT=1/WR_WAIT=1/TURN=3 instance, each attached to a behavioural
// asynchronous RAM. Expected timing is derived from the wait parameters and
// expected data from a word-array reference memory.
`timescale 1ns/1ps
module tb_async_ram_ctrl;
  localparam int unsigned AW = 23;

  typedef struct packed {
    logic          ready;
    logic          rdValid;
    logic          wrDone;
    logic [4:0]    strb;     // {RamCE, MemOE, MemWE, RamLB, RamUB}
    logic [15:0]   db;
    logic [15:0]   rdData;
    logic [AW-1:0] adr;
  } snap_t;

  logic          clk      = 1'b0;
  logic          rstn     = 1'b0;
  logic          ramInit  = 1'b0;
  bit            sel      = 1'b0;
  logic          drvValid = 1'b0;
  logic          drvWe    = 1'b0;
  logic [AW-1:0] drvAddr  = '0;
  logic [15:0]   drvWdata = '0;
  logic [1:0]    drvBe    = '0;
  int            errors   = 0;
  int            checks   = 0;
  logic [15:0]   refMem [2][256];

  always #5 clk = ~clk;

  async_ram_ctrl_if #(.ADDR_W(AW)) h0 ();
  async_ram_ctrl_if #(.ADDR_W(AW)) h1 ();

  assign h0.req_valid = drvValid && !sel;
  assign h1.req_valid = drvValid && sel;
  assign h0.req_we    = drvWe;
  assign h1.req_we    = drvWe;
  assign h0.req_addr  = drvAddr;
  assign h1.req_addr  = drvAddr;
  assign h0.req_wdata = drvWdata;
  assign h1.req_wdata = drvWdata;
  assign h0.req_be    = drvBe;
  assign h1.req_be    = drvBe;

  wire  [15:0]   db0;
  wire  [15:0]   db1;
  logic [AW-1:0] adr0, adr1;
  logic          ce0, oe0, we0, lb0, ub0, adv0, rclk0, fce0;
  logic          ce1, oe1, we1, lb1, ub1, adv1, rclk1, fce1;
  logic [15:0]   mem0 [256];
  logic [15:0]   mem1 [256];

  async_ram_ctrl #(.ADDR_W(AW)) u0 (
    .clk(clk), .rstn(rstn), .host(h0), .MemAdr(adr0), .MemDB(db0),
    .RamCE(ce0), .MemOE(oe0), .MemWE(we0), .RamLB(lb0), .RamUB(ub0),
    .RamAdv(adv0), .RamClk(rclk0), .FlashCE(fce0)
  );

  async_ram_ctrl #(.ADDR_W(AW), .RD_WAIT(1), .WR_WAIT(1), .TURN(3)) u1 (
    .clk(clk), .rstn(rstn), .host(h1), .MemAdr(adr1), .MemDB(db1),
    .RamCE(ce1), .MemOE(oe1), .MemWE(we1), .RamLB(lb1), .RamUB(ub1),
    .RamAdv(adv1), .RamClk(rclk1), .FlashCE(fce1)
  );

  // Behavioural asynchronous RAMs: combinational read, lane-masked write while WE is low.
  assign db0 = (!ce0 && !oe0 && we0) ? mem0[adr0[7:0]] : 16'hzzzz;
  assign db1 = (!ce1 && !oe1 && we1) ? mem1[adr1[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 256; i++) mem0[i] <= '0;
    end else if (!ce0 && !we0) begin
      if (!lb0) mem0[adr0[7:0]][7:0]  <= db0[7:0];
      if (!ub0) mem0[adr0[7:0]][15:8] <= db0[15:8];
    end
  end

  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 256; i++) mem1[i] <= '0;
    end else if (!ce1 && !we1) begin
      if (!lb1) mem1[adr1[7:0]][7:0]  <= db1[7:0];
      if (!ub1) mem1[adr1[7:0]][15:8] <= db1[15:8];
    end
  end

  function automatic int rdW(input bit s); return s ? 1 : 4; endfunction
  function automatic int wrW(input bit s); return s ? 1 : 4; endfunction
  function automatic int trn(input bit s); return s ? 3 : 1; endfunction

  function automatic snap_t snap(input bit s);
    snap_t p;
    if (s) begin
      p.ready = h1.req_ready; p.rdValid = h1.rd_valid; p.wrDone = h1.wr_done;
      p.strb  = {ce1, oe1, we1, lb1, ub1}; p.db = db1; p.rdData = h1.rd_data; p.adr = adr1;
    end else begin
      p.ready = h0.req_ready; p.rdValid = h0.rd_valid; p.wrDone = h0.wr_done;
      p.strb  = {ce0, oe0, we0, lb0, ub0}; p.db = db0; p.rdData = h0.rd_data; p.adr = adr0;
    end
    return p;
  endfunction

  function automatic logic [AW-1:0] rndAddr();
    return {15'($urandom), 8'($urandom_range(0, 254))};
  endfunction

  function automatic logic [15:0] rndData();
    logic [15:0] d;
    d = 16'($urandom);
    if (d == 16'h0000) d = 16'h0001;
    return d;
  endfunction

  task automatic refWrite(input bit s, input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
    if (be[0]) refMem[s][a[7:0]][7:0]  = d[7:0];
    if (be[1]) refMem[s][a[7:0]][15:8] = d[15:8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input bit s);
    snap_t p;
    int    n;
    n = 0;
    p = snap(s);
    while (!p.ready && n < 50) begin
      tick();
      n++;
      p = snap(s);
    end
    checks++;
    if (!p.ready) begin
      errors++;
      $display("FAIL wait_ready inst%0d: req_ready=%b, required 1 within 50 cycles", s, p.ready);
    end
  endtask

  // One access from idle; every cycle until ready returns is checked against the parameter-derived timeline.
  task automatic access(input bit s, input bit isWr, input logic [AW-1:0] a, input logic [15:0] wd,
                        input logic [1:0] be, output logic [15:0] got);
    snap_t       p;
    int          w, t;
    logic [15:0] expRd;
    logic [4:0]  eS;
    logic [2:0]  eF;
    w = isWr ? wrW(s) : rdW(s);
    t = trn(s);
    got = '0;
    waitReady(s);
    sel = s; drvWe = isWr; drvAddr = a; drvWdata = wd; drvBe = be; drvValid = 1'b1;
    expRd = refMem[s][a[7:0]];
    if (isWr) refWrite(s, a, wd, be);
    for (int k = 1; k <= w + t + 1; k++) begin
      tick();
      if (k == 1) drvValid = 1'b0;
      p = snap(s);
      if (k <= w) eS = isWr ? {1'b0, 1'b1, 1'b0, ~be[0], ~be[1]} : 5'b00100;
      else        eS = 5'b11111;
      eF = {k == w + t + 1, !isWr && k == w + 1, isWr && k == w + 1};
      checks++;
      if (p.strb !== eS) begin
        errors++;
        $display("FAIL strobes inst%0d we=%0d cycle %0d: CE/OE/WE/LB/UB=%b required %b", s, isWr, k, p.strb, eS);
      end
      checks++;
      if ({p.ready, p.rdValid, p.wrDone} !== eF) begin
        errors++;
        $display("FAIL flags inst%0d we=%0d cycle %0d: ready/rd_valid/wr_done=%b required %b", s, isWr, k,
                 {p.ready, p.rdValid, p.wrDone}, eF);
      end
      checks++;
      if (p.adr !== a) begin
        errors++;
        $display("FAIL mem_adr inst%0d cycle %0d: MemAdr=%h required %h", s, k, p.adr, a);
      end
      if (isWr) begin
        checks++;
        if (k <= w + 1 && p.db !== wd) begin
          errors++;
          $display("FAIL bus_drive inst%0d cycle %0d: MemDB=%h required %h", s, k, p.db, wd);
        end else if (k > w + 1 && p.db === wd) begin
          errors++;
          $display("FAIL bus_release inst%0d cycle %0d: MemDB=%h still carries write data", s, k, p.db);
        end
      end else if (k <= w) begin
        checks++;
        if (p.db !== expRd) begin
          errors++;
          $display("FAIL read_bus inst%0d cycle %0d: MemDB=%h required %h", s, k, p.db, expRd);
        end
      end
      if (!isWr && k == w + 1) begin
        got = p.rdData;
        checks++;
        if (p.rdData !== expRd) begin
          errors++;
          $display("FAIL rd_data inst%0d addr %h: rd_data=%h required %h", s, a, p.rdData, expRd);
        end
      end
    end
  endtask

  task automatic test_reset();
    snap_t p;
    rstn = 1'b0; ramInit = 1'b1; drvValid = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) refMem[s][i] = '0;
    repeat (3) tick();
    ramInit = 1'b0;
    for (int s = 0; s < 2; s++) begin
      p = snap(1'(s));
      checks++;
      if (p.strb !== 5'b11111 || p.adr !== '0 || p.rdData !== 16'h0000 || p.rdValid !== 1'b0 || p.wrDone !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d: strb=%b adr=%h rd_data=%h rd_valid=%b wr_done=%b required 11111/0/0/0/0",
                 s, p.strb, p.adr, p.rdData, p.rdValid, p.wrDone);
      end
    end
    checks++;
    if ({adv0, rclk0, fce0, adv1, rclk1, fce1} !== 6'b001001) begin
      errors++;
      $display("FAIL tie_offs: Adv/Clk/FlashCE=%b required 001001", {adv0, rclk0, fce0, adv1, rclk1, fce1});
    end
    rstn = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      p = snap(1'(s));
      checks++;
      if (p.ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready inst%0d: req_ready=%b required 1", s, p.ready);
      end
    end
  endtask

  task automatic test_read_default();
    logic [15:0] got;
    access(1'b0, 1'b1, 23'h00ABCD, 16'h1234, 2'b11, got);
    access(1'b0, 1'b0, 23'h00ABCD, 16'h0000, 2'b00, got);
    checks++;
    if (got !== 16'h1234) begin
      errors++;
      $display("FAIL read_default: rd_data=%h required 1234", got);
    end
  endtask

  task automatic test_write_default();
    logic [15:0] got;
    access(1'b0, 1'b1, 23'h000010, 16'hBEEF, 2'b11, got);
    access(1'b0, 1'b0, 23'h000010, 16'h0000, 2'b00, got);
    checks++;
    if (got !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_readback: rd_data=%h required beef", got);
    end
  endtask

  task automatic test_byte_write();
    logic [15:0] got;
    access(1'b0, 1'b1, 23'h000020, 16'hFFFF, 2'b11, got);
    access(1'b0, 1'b1, 23'h000020, 16'h55AA, 2'b01, got);
    access(1'b0, 1'b0, 23'h000020, 16'h0000, 2'b00, got);
    checks++;
    if (got !== 16'hFFAA) begin
      errors++;
      $display("FAIL byte_write: rd_data=%h required ffaa", got);
    end
    access(1'b0, 1'b1, 23'h000020, 16'h1111, 2'b00, got);
    access(1'b0, 1'b0, 23'h000020, 16'h0000, 2'b00, got);
    checks++;
    if (got !== 16'hFFAA) begin
      errors++;
      $display("FAIL zero_be_write: rd_data=%h required ffaa", got);
    end
  endtask

  task automatic test_scaled();
    logic [15:0] got;
    access(1'b1, 1'b1, 23'h000033, 16'hC0DE, 2'b11, got);
    access(1'b1, 1'b0, 23'h000033, 16'h0000, 2'b00, got);
    checks++;
    if (got !== 16'hC0DE) begin
      errors++;
      $display("FAIL scaled_readback: rd_data=%h required c0de", got);
    end
    access(1'b1, 1'b1, 23'h000033, 16'h00FF, 2'b10, got);
    access(1'b1, 1'b0, 23'h000033, 16'h0000, 2'b00, got);
    checks++;
    if (got !== 16'h00DE) begin
      errors++;
      $display("FAIL scaled_byte_write: rd_data=%h required 00de", got);
    end
  endtask

  // req_valid held high; alternating write then read-back of the same address.
  task automatic test_back_to_back(input bit s);
    snap_t       p;
    int          per, cyc, lastAcc, accCnt;
    logic [15:0] expQ [$];
    logic [15:0] e;
    per = rdW(s) + trn(s) + 1;
    waitReady(s);
    sel = s;
    accCnt = 0; lastAcc = -1; cyc = 0;
    drvWe = 1'b1; drvAddr = rndAddr(); drvWdata = rndData(); drvBe = 2'($urandom); drvValid = 1'b1;
    while (accCnt < 20 && cyc < 400) begin
      p = snap(s);
      if (!p.strb[3]) begin
        checks++;
        if (p.db !== refMem[s][p.adr[7:0]]) begin
          errors++;
          $display("FAIL b2b_oe_bus inst%0d cyc %0d: MemDB=%h required %h", s, cyc, p.db, refMem[s][p.adr[7:0]]);
        end
      end
      checks++;
      if (p.rdValid && p.wrDone) begin
        errors++;
        $display("FAIL b2b_pulse_excl inst%0d cyc %0d: rd_valid=%b wr_done=%b", s, cyc, p.rdValid, p.wrDone);
      end
      if (p.rdValid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_rd inst%0d cyc %0d: rd_valid=1 required 0", s, cyc);
        end else begin
          e = expQ.pop_front();
          if (p.rdData !== e) begin
            errors++;
            $display("FAIL b2b_rd_data inst%0d cyc %0d: rd_data=%h required %h", s, cyc, p.rdData, e);
          end
        end
      end
      if (p.ready) begin
        if (lastAcc >= 0) begin
          checks++;
          if (cyc - lastAcc != per) begin
            errors++;
            $display("FAIL b2b_period inst%0d: accept spacing=%0d required %0d", s, cyc - lastAcc, per);
          end
        end
        lastAcc = cyc;
        accCnt++;
        if (drvWe) refWrite(s, drvAddr, drvWdata, drvBe);
        else expQ.push_back(refMem[s][drvAddr[7:0]]);
        tick();
        cyc++;
        if (accCnt == 20) drvValid = 1'b0;
        else if (drvWe) drvWe = 1'b0;
        else begin
          drvWe = 1'b1; drvAddr = rndAddr(); drvWdata = rndData(); drvBe = 2'($urandom);
        end
      end else begin
        tick();
        cyc++;
      end
    end
    drvValid = 1'b0;
    checks++;
    if (accCnt != 20) begin
      errors++;
      $display("FAIL b2b_accepts inst%0d: accepted=%0d required 20", s, accCnt);
    end
    for (int n = 0; n < 12 && expQ.size() > 0; n++) begin
      p = snap(s);
      if (p.rdValid) begin
        e = expQ.pop_front();
        checks++;
        if (p.rdData !== e) begin
          errors++;
          $display("FAIL b2b_last_rd inst%0d: rd_data=%h required %h", s, p.rdData, e);
        end
      end
      tick();
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing_rd inst%0d: %0d reads without rd_valid, required 0", s, expQ.size());
    end
  endtask

  task automatic test_reset_mid_write();
    snap_t p;
    int    seen;
    waitReady(1'b0);
    sel = 1'b0;
    drvWe = 1'b1; drvAddr = 23'h0000FF; drvWdata = 16'hA5C3; drvBe = 2'b11; drvValid = 1'b1;
    tick();
    drvValid = 1'b0;
    tick();
    rstn = 1'b0; drvWe = 1'b0; drvAddr = 23'h000010; drvValid = 1'b1;
    tick();
    p = snap(1'b0);
    checks++;
    if (p.strb !== 5'b11111 || p.wrDone !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobes: strb=%b wr_done=%b required 11111/0", p.strb, p.wrDone);
    end
    checks++;
    if (p.db === 16'hA5C3) begin
      errors++;
      $display("FAIL abort_bus: MemDB=%h still carries write data", p.db);
    end
    tick();
    p = snap(1'b0);
    checks++;
    if (p.strb !== 5'b11111) begin
      errors++;
      $display("FAIL accept_in_reset: strb=%b required 11111", p.strb);
    end
    rstn = 1'b1; drvValid = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      p = snap(1'b0);
      if (p.wrDone || p.rdValid) seen++;
    end
    checks++;
    if (seen != 0 || p.ready !== 1'b1 || p.strb !== 5'b11111) begin
      errors++;
      $display("FAIL after_abort: pulses=%0d ready=%b strb=%b required 0/1/11111", seen, p.ready, p.strb);
    end
  endtask

  task automatic test_random();
    logic [15:0] got;
    bit          s, isWr;
    for (int n = 0; n < 40; n++) begin
      s    = 1'($urandom_range(0, 1));
      isWr = 1'($urandom_range(0, 1));
      access(s, isWr, rndAddr(), rndData(), 2'($urandom), got);
    end
  endtask

  initial begin
    test_reset();
    test_read_default();
    test_write_default();
    test_byte_write();
    test_scaled();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
